// File: rtl/hello_disp_pkg.sv
// hello_disp_pkg
//   Shared definitions for the scrolling "HELLO" seven-segment display:
//   3-bit character codes, the matching active-low segment patterns
//   (bit6=g .. bit0=a), the blank pattern and the power-up message.
package hello_disp_pkg;

   // Character codes stored in the message buffer
   localparam logic [2:0] CH_H     = 3'd0;
   localparam logic [2:0] CH_E     = 3'd1;
   localparam logic [2:0] CH_L     = 3'd2;
   localparam logic [2:0] CH_O     = 3'd3;
   localparam logic [2:0] CH_P     = 3'd4;
   localparam logic [2:0] CH_A     = 3'd5;
   localparam logic [2:0] CH_DASH  = 3'd6;
   localparam logic [2:0] CH_BLANK = 3'd7;

   // Active-low segment patterns, g..a
   localparam logic [6:0] SEG_H     = 7'b0001001;
   localparam logic [6:0] SEG_E     = 7'b0000110;
   localparam logic [6:0] SEG_L     = 7'b1000111;
   localparam logic [6:0] SEG_O     = 7'b1000000;
   localparam logic [6:0] SEG_P     = 7'b0001100;
   localparam logic [6:0] SEG_A     = 7'b0001000;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Message loaded at reset: H E L L O followed by blanks
   function automatic logic [2:0] hello_init(input int idx);
      case (idx)
         0:       return CH_H;
         1:       return CH_E;
         2:       return CH_L;
         3:       return CH_L;
         4:       return CH_O;
         default: return CH_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/char7seg_decoder.sv
// char7seg_decoder
//   Combinational decode of a 3-bit character code to an active-low
//   seven-segment pattern.
//   Ports:
//     code    in  3  character code
//     pattern out 7  active-low segments, bit6=g .. bit0=a
module char7seg_decoder
   import hello_disp_pkg::*;
(
   input  logic [2:0] code,
   output logic [6:0] pattern
);

   always_comb begin
      pattern = SEG_BLANK;
      case (code)
         CH_H:     pattern = SEG_H;
         CH_E:     pattern = SEG_E;
         CH_L:     pattern = SEG_L;
         CH_O:     pattern = SEG_O;
         CH_P:     pattern = SEG_P;
         CH_A:     pattern = SEG_A;
         CH_DASH:  pattern = SEG_DASH;
         default:  pattern = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/hello_scroll_display.sv
// hello_scroll_display
//   Drives NUM_DIGITS seven-segment digits from a small writable message
//   buffer, with optional scrolling and blinking paced by a prescaler tick.
//   Ports:
//     clk      in  1           clock, rising edge
//     rst      in  1           synchronous active-high reset
//     mode     in  2           bit0 = scroll, bit1 = blink
//     msg_len  in  LW          active message length (clamped to MSG_DEPTH)
//     wr_en    in  1           buffer write enable
//     wr_addr  in  AW          buffer write address
//     wr_data  in  3           character code to write
//     seg      out 7*NUM_DIGITS registered active-low segments, digit
//                              NUM_DIGITS-1 leftmost
//     wrap     out 1           pulse when the scroll offset wraps to 0
module hello_scroll_display
   import hello_disp_pkg::*;
#(
   parameter  int NUM_DIGITS = 8,
   parameter  int MSG_DEPTH  = 16,
   parameter  int TICK_DIV   = 25_000_000,
   localparam int AW         = $clog2(MSG_DEPTH),
   localparam int LW         = $clog2(MSG_DEPTH + 1)
)
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [1:0]              mode,
   input  logic [LW-1:0]           msg_len,
   input  logic                    wr_en,
   input  logic [AW-1:0]           wr_addr,
   input  logic [2:0]              wr_data,
   output logic [7*NUM_DIGITS-1:0] seg,
   output logic                    wrap
);

   localparam int            PW      = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

   logic [PW-1:0] pre_cnt;
   logic          tick;
   logic [2:0]    msg_buf [MSG_DEPTH];
   logic [AW-1:0] offset;
   logic          phase;

   logic          scroll_en;
   logic          blink_en;
   logic [LW-1:0] len_e;
   logic [LW-1:0] off_ext;
   logic [LW-1:0] off_inc;
   logic [AW-1:0] off_next;
   logic          wrap_next;
   logic          blank_all;

   logic [2:0]    code [NUM_DIGITS];
   logic [6:0]    pat  [NUM_DIGITS];

   assign tick      = (pre_cnt == PRE_MAX);
   assign scroll_en = mode[0];
   assign blink_en  = mode[1];
   assign len_e     = (msg_len > LW'(MSG_DEPTH)) ? LW'(MSG_DEPTH) : msg_len;
   assign off_ext   = LW'(offset);
   assign off_inc   = off_ext + LW'(1);
   assign blank_all = (len_e == '0) || (blink_en && phase);

   // Next scroll offset. An offset left out of range by a shrinking length
   // (or an empty message) collapses to 0 silently; only a tick-driven
   // step back to 0 raises wrap.
   always_comb begin
      off_next  = '0;
      wrap_next = 1'b0;
      if (scroll_en && (len_e != '0) && (off_ext < len_e)) begin
         if (tick) begin
            if (off_inc == len_e) wrap_next = 1'b1;
            else                  off_next  = AW'(off_inc);
         end else begin
            off_next = offset;
         end
      end
   end

   // Character shown on each digit: leftmost shows buf[offset], each digit
   // to the right advances one position, wrapping modulo len_e.
   always_comb begin
      int pos;
      pos = 0;
      for (int d = 0; d < NUM_DIGITS; d++) begin
         code[d] = CH_BLANK;
         if (len_e != '0) begin
            pos     = (int'(offset) + (NUM_DIGITS - 1 - d)) % int'(len_e);
            code[d] = msg_buf[AW'(pos)];
         end
      end
   end

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
      char7seg_decoder u_dec (
         .code    (code[g]),
         .pattern (pat[g])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pre_cnt <= '0;
         offset  <= '0;
         phase   <= 1'b0;
         wrap    <= 1'b0;
         seg     <= '1;
         for (int i = 0; i < MSG_DEPTH; i++) msg_buf[i] <= hello_init(i);
      end else begin
         pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
         offset  <= off_next;
         wrap    <= wrap_next;
         phase   <= blink_en ? (phase ^ tick) : 1'b0;
         if (wr_en && (int'(wr_addr) < MSG_DEPTH)) msg_buf[wr_addr] <= wr_data;
         for (int d = 0; d < NUM_DIGITS; d++)
            seg[7*d +: 7] <= blank_all ? SEG_BLANK : pat[d];
      end
   end

endmodule

// File: tb/tb_hello_scroll_display.sv
// tb_hello_scroll_display
//   Self-checking bench: a behavioural display model predicts seg/wrap every
//   cycle, plus literal expectations for the key visible patterns.
module tb_hello_scroll_display;

   localparam int ND = 8;
   localparam int MD = 16;
   localparam int TD = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  mode;
   logic [4:0]  msg_len;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [2:0]  wr_data;
   logic [55:0] seg;
   logic        wrap;

   hello_scroll_display #(.NUM_DIGITS(ND), .MSG_DEPTH(MD), .TICK_DIV(TD)) dut (
      .clk     (clk),
      .rst     (rst),
      .mode    (mode),
      .msg_len (msg_len),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .seg     (seg),
      .wrap    (wrap)
   );

   always #5 clk = ~clk;

   // Literal expectations, leftmost digit first
   localparam logic [55:0] ALL_BLANK = {56{1'b1}};
   localparam logic [55:0] LIT_HELLO = {7'h09, 7'h06, 7'h47, 7'h47, 7'h40, 7'h7f, 7'h7f, 7'h7f};
   localparam logic [55:0] LIT_HELLOHEL = {7'h09, 7'h06, 7'h47, 7'h47, 7'h40, 7'h09, 7'h06, 7'h47};
   localparam logic [55:0] LIT_ELLOHELL = {7'h06, 7'h47, 7'h47, 7'h40, 7'h09, 7'h06, 7'h47, 7'h47};

   // Segment table: H E L O P A dash blank
   logic [6:0] pat_tab [8] = '{7'h09, 7'h06, 7'h47, 7'h40, 7'h0C, 7'h08, 7'h3F, 7'h7F};

   // Model state
   int          m_buf [MD];
   int          m_off;
   int          m_phase;
   int          m_cyc;
   logic [55:0] m_seg;
   logic        m_wrap;

   int n_cmp = 0;
   int n_bad = 0;
   int n_wrap = 0;

   task automatic check(input string name, input logic [55:0] act, input logic [55:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // What the display must show for the current model state
   function automatic logic [55:0] render(input int le, input logic [1:0] md);
      logic [55:0] r;
      int ch;
      r = '0;
      for (int p = 0; p < ND; p++) begin
         if (le == 0 || (md[1] && m_phase == 1)) ch = 7;
         else ch = m_buf[(m_off + p) % le];
         r[7*(ND-1-p) +: 7] = pat_tab[ch];
      end
      return r;
   endfunction

   task automatic model_update();
      int le;
      bit tk;
      if (rst) begin
         for (int i = 0; i < MD; i++) m_buf[i] = 7;
         m_buf[0] = 0; m_buf[1] = 1; m_buf[2] = 2; m_buf[3] = 2; m_buf[4] = 3;
         m_off = 0; m_phase = 0; m_cyc = 0; m_seg = ALL_BLANK; m_wrap = 1'b0;
         return;
      end
      tk = (m_cyc % TD) == TD - 1;
      le = (int'(msg_len) > MD) ? MD : int'(msg_len);
      m_seg  = render(le, mode);
      m_wrap = 1'b0;
      if (mode[0]) begin
         if (le == 0 || m_off >= le) m_off = 0;
         else if (tk) begin
            m_off = (m_off + 1) % le;
            if (m_off == 0) m_wrap = 1'b1;
         end
      end else begin
         m_off = 0;
      end
      if (mode[1]) begin
         if (tk) m_phase = 1 - m_phase;
      end else begin
         m_phase = 0;
      end
      if (wr_en) m_buf[wr_addr] = int'(wr_data);
      m_cyc++;
   endtask

   // One clock: model advances at the edge, outputs compared mid-cycle
   task automatic step();
      @(posedge clk);
      model_update();
      @(negedge clk);
      check("seg", seg, m_seg);
      check("wrap", {55'b0, wrap}, {55'b0, m_wrap});
      if (wrap === 1'b1) n_wrap++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      int guard;
      rst = 1'b1; mode = 2'd0; msg_len = 5'd8;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;

      // Reset, then static HELLO
      step();
      check("reset_blank", seg, ALL_BLANK);
      rst = 1'b0;
      step();
      check("hello_static", seg, LIT_HELLO);
      run(6);

      // Scroll, length 5
      rst = 1'b1; mode = 2'd1; msg_len = 5'd5;
      step();
      rst = 1'b0;
      run(5);
      check("scroll_first_tick", seg, LIT_ELLOHELL);
      n_wrap = 0;
      run(40);
      check("wrap_per_20", 56'(n_wrap), 56'd2);

      // Blink, length 5
      rst = 1'b1; mode = 2'd2; msg_len = 5'd5;
      step();
      rst = 1'b0;
      run(5);
      check("blink_off", seg, ALL_BLANK);
      run(4);
      check("blink_on", seg, LIT_HELLOHEL);
      run(8);

      // Writes during scroll, length 7
      rst = 1'b1; mode = 2'd1; msg_len = 5'd7;
      step();
      rst = 1'b0;
      run(2);
      wr_en = 1'b1; wr_addr = 4'd5; wr_data = 3'd4;
      step();
      wr_addr = 4'd6; wr_data = 3'd5;
      step();
      wr_en = 1'b0;
      n_wrap = 0;
      run(56);
      check("wrap_per_28", 56'(n_wrap), 56'd2);

      // Length shrink, zero length, oversize length, scroll+blink
      rst = 1'b1; mode = 2'd1; msg_len = 5'd16;
      step();
      rst = 1'b0;
      guard = 0;
      while (m_off != 6 && guard < 100) begin
         step();
         guard++;
      end
      check("reach_offset6", 56'(guard < 100), 56'd1);
      msg_len = 5'd3;
      step();
      check("shrink_no_wrap", {55'b0, wrap}, 56'd0);
      run(3);
      msg_len = 5'd0;
      run(2);
      check("len0_blank", seg, ALL_BLANK);
      msg_len = 5'd20;
      run(10);
      mode = 2'd3;
      run(12);

      // Reset mid-scroll with a simultaneous write
      rst = 1'b1; wr_en = 1'b1; wr_addr = 4'd0; wr_data = 3'd4;
      mode = 2'd1; msg_len = 5'd5;
      step();
      rst = 1'b0; wr_en = 1'b0;
      run(4);
      check("rst_write_lost", seg, LIT_HELLOHEL);
      run(1);
      check("rst_first_tick", seg, LIT_ELLOHELL);
      run(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/hello_scroll_display.md
HELLO_SCROLL_DISPLAY -- requirements
Module: hello_scroll_display

Interface
REQ-001 Parameter NUM_DIGITS, default 8, number of seven-segment digits driven.
REQ-002 Parameter MSG_DEPTH, default 16, message buffer entries (3-bit char codes); AW = clog2(MSG_DEPTH), LW = clog2(MSG_DEPTH+1).
REQ-003 Parameter TICK_DIV, default 25_000_000, clk cycles per scroll/blink tick (>=2).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 mode  input  2  0 static, 1 scroll, 2 blink, 3 scroll+blink.
REQ-007 msg_len  input  LW  active message length in entries.
REQ-008 wr_en / wr_addr / wr_data  input  1 / AW / 3  buffer write port.
REQ-009 seg  output  7*NUM_DIGITS  active-low segments; digit d at seg[7*d+6:7*d], bit6=g..bit0=a; digit NUM_DIGITS-1 is leftmost.
REQ-010 wrap  output  1  one-cycle pulse when scroll offset wraps to 0.

Function
REQ-011 Char codes SHALL be 0 H, 1 E, 2 L, 3 O, 4 P, 5 A, 6 dash, 7 blank.
REQ-012 Active-low patterns (g..a) SHALL be H 0001001, E 0000110, L 1000111, O 1000000, P 0001100, A 0001000, dash 0111111, blank 1111111.
REQ-013 Prescaler SHALL count 0..TICK_DIV-1 continuously; internal tick asserted for the one cycle the count equals TICK_DIV-1.
REQ-014 Effective length len_e SHALL be min(msg_len, MSG_DEPTH); len_e=0 SHALL blank all digits and hold offset at 0.
REQ-015 Leftmost digit SHALL show buf[offset], next digit buf[(offset+1) mod len_e], etc.; positions wrap modulo len_e, including len_e < NUM_DIGITS.
REQ-016 Modes 1/3: on tick, offset <= (offset+1) mod len_e; wrap pulses in the cycle after the tick that yields offset 0.
REQ-017 Modes 0/2: offset SHALL be forced to 0 every cycle; wrap stays 0.
REQ-018 Modes 2/3: blink phase SHALL toggle on every tick; phase 1 forces all digits to blank; modes 0/1 hold phase at 0.
REQ-019 If offset >= len_e (length shrunk), offset SHALL become 0 next cycle without a wrap pulse.
REQ-020 seg SHALL be registered: seg reflects buffer, offset, phase, mode, msg_len of the previous cycle (1-cycle latency).
REQ-021 Write SHALL update buf[wr_addr] at the edge; a same-cycle display read sees the old value, new value appears one cycle later; wr_addr >= MSG_DEPTH is ignored.
REQ-022 Mode change SHALL take effect on the next edge; prescaler is not restarted by mode or length changes.

Reset
REQ-023 On rst, buf[0..4] SHALL load H,E,L,L,O and all other entries blank.
REQ-024 On rst, offset, prescaler, blink phase and wrap SHALL be 0 and seg all ones (blank).
REQ-025 rst SHALL override any same-cycle write or tick; reset mid-scroll restarts from offset 0 with a full TICK_DIV period before the first tick.

Structure
REQ-026 Package hello_disp_pkg SHALL hold char-code constants, the eight segment patterns, and the blank pattern.
REQ-027 Sub-module char7seg_decoder (3-bit code -> 7-bit active-low pattern, combinational) SHALL be instantiated NUM_DIGITS times.
REQ-028 Implementation SHALL use no latches and no clock gating; buffer is a register array.

Verification (NUM_DIGITS=8, MSG_DEPTH=16, TICK_DIV=4)
REQ-029 rst 1 cycle, mode 0, msg_len 8 -> seg blank one cycle, then digits left->right H E L L O blank blank blank.
REQ-030 mode 1, msg_len 5 -> after each tick, leftmost steps E,L,L,O,H; wrap pulses once per 20 cycles; leftmost 8 digits after 1st tick E L L O H E L L.
REQ-031 mode 2, msg_len 5 -> seg alternates HELLO-pattern / all 1111111 every 4 cycles, offset stays 0.
REQ-032 write addr 5 = P, addr 6 = A during mode 1 with msg_len 7 -> P appears exactly one cycle after write; wrap period becomes 28 cycles.
REQ-033 offset 6, msg_len changed to 3 -> offset 0 next cycle, no wrap; msg_len 0 -> all digits blank; msg_len 20 -> treated as 16.
REQ-034 rst asserted mid-scroll with simultaneous wr_en -> buffer restored to HELLO, write lost, first tick 4 cycles after rst release.
